uart_tx: RTL and testbench

Byte-serial UART transmitter: 8 data bits, one start bit, one stop bit, no parity, LSB first. It buffers bytes from the host side in a small FIFO and shifts them out on o_Tx_Serial at CLKS_PER_BIT clocks per bit. It is the transmit-side companion to the UART receiver, and both use the same CLKS_PER_BIT convention (clock frequency / baud rate).

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_fifo.sv | 38 +++
 rtl/uart_tx.sv | 79 +++++++
 tb/tb_uart_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and frame constants
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with occupancy count
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge i_Clock)
        if (do_push) mem[wr_ptr] <= wr_data;
    always_ff @(posedge i_Clock or negedge i_Rst_n)
        if (!i_Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter, LSB first
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            i_Clock,
    input  logic                            i_Rst_n,
    input  logic                            i_Tx_DV,
    input  logic [UART_DATA_BITS-1:0]       i_Tx_Byte,
    output logic                            o_Tx_Ready,
    output logic                            o_Tx_Serial,
    output logic                            o_Tx_Active,
    output logic                            o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]     o_Fifo_Count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(UART_DATA_BITS - 1);
    tx_state_t state, next_state;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_idx;
    logic [UART_DATA_BITS-1:0] shift, fifo_data;
    logic pop, fifo_full, fifo_empty, cnt_last;
    assign cnt_last = clk_cnt == CNT_MAX;
    uart_tx_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_Clock(i_Clock),
        .i_Rst_n(i_Rst_n),
        .push(i_Tx_DV && o_Tx_Ready),
        .wr_data(i_Tx_Byte),
        .pop(pop),
        .rd_data(fifo_data),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(o_Fifo_Count)
    );
    always_comb begin
        next_state = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                pop = !fifo_empty;
                next_state = fifo_empty ? IDLE : START;
            end
            START: next_state = cnt_last ? DATA : START;
            DATA: next_state = (cnt_last && bit_idx == BIT_MAX) ? STOP : DATA;
            STOP: next_state = cnt_last ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
    end
    // Outputs are registered from the current state, so the line trails the FSM by one clock
    always_ff @(posedge i_Clock or negedge i_Rst_n)
        if (!i_Rst_n) begin
            state <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done <= 1'b0;
            o_Tx_Ready <= 1'b1;
        end else begin
            state <= next_state;
            if (pop) begin
                shift <= fifo_data;
                clk_cnt <= '0;
                bit_idx <= '0;
            end else if (state != IDLE) begin
                clk_cnt <= cnt_last ? '0 : clk_cnt + 1'b1;
                if (state == DATA && cnt_last) bit_idx <= bit_idx + 1'b1;
            end
            o_Tx_Serial <= (state == START) ? 1'b0 : (state == DATA) ? shift[bit_idx] : 1'b1;
            o_Tx_Active <= state != IDLE;
            o_Tx_Done <= state == STOP && cnt_last;
            o_Tx_Ready <= !fifo_full;
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and loopback checks for the buffered UART transmitter
module tb_uart_tx;
    localparam int CPB = 5;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct { logic [7:0] data; logic [9:0] line; } vec_t;
    typedef struct { int e; logic [2:0] count; logic ready; } fill_t;
    typedef struct { int e; logic serial; logic [2:0] count; logic done; } b2b_t;

    logic clk = 1'b0, rst_n = 1'b0, dv = 1'b0;
    logic [7:0] tx_byte = '0;
    logic ready, serial, active, done;
    logic [CW-1:0] count;
    int n_checks = 0, n_fail = 0, done_cnt = 0, edge_n = 0;
    logic [9:0] rx_q[$];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(ready), .o_Tx_Serial(serial), .o_Tx_Active(active),
        .o_Tx_Done(done), .o_Fifo_Count(count)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Reference receiver: detect start low, sample each bit at its middle
    initial begin : rx
        logic [9:0] line;
        logic abort;
        forever begin
            @(negedge clk);
            if (rst_n && serial === 1'b0) begin
                abort = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    repeat (k == 0 ? 2 : CPB) begin
                        @(negedge clk);
                        if (!rst_n) abort = 1'b1;
                    end
                    line[k] = serial;
                end
                if (!abort) rx_q.push_back(line);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic goto_edge(input int t);
        while (edge_n < t) tick();
    endtask

    task automatic write_byte(input logic [7:0] b);
        dv = 1'b1;
        tx_byte = b;
        tick();
        dv = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        int budget = 60 * (target - done_cnt) + 20;
        while (done_cnt < target && t < budget) begin
            tick();
            t++;
        end
        chk("done_wait", 32'(done_cnt >= target), 1);
    endtask

    task automatic rx_chk(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = (rx_q.size() != 0) ? rx_q.pop_front() : 10'bx;
        chk(name, got, exp);
    endtask

    initial begin
        vec_t vecs[7];
        fill_t fill_pts[14];
        b2b_t b2b_pts[8];
        logic [7:0] fill_bytes[6];
        logic [7:0] b;
        int base;
        vecs = '{'{8'hA5, 10'b1_10100101_0}, '{8'h00, 10'b1_00000000_0},
                 '{8'hFF, 10'b1_11111111_0}, '{8'h3C, 10'b1_00111100_0},
                 '{8'h81, 10'b1_10000001_0}, '{8'h5A, 10'b1_01011010_0},
                 '{8'h01, 10'b1_00000001_0}};
        fill_pts = '{'{0, 3'd1, 1'b1}, '{1, 3'd1, 1'b1}, '{2, 3'd2, 1'b1}, '{3, 3'd3, 1'b1},
                     '{4, 3'd4, 1'b1}, '{5, 3'd4, 1'b0}, '{6, 3'd4, 1'b0}, '{7, 3'd4, 1'b0},
                     '{51, 3'd4, 1'b0}, '{52, 3'd3, 1'b0}, '{53, 3'd3, 1'b1}, '{54, 3'd4, 1'b1},
                     '{55, 3'd4, 1'b0}, '{56, 3'd4, 1'b0}};
        b2b_pts = '{'{51, 1'b1, 3'd2, 1'b1}, '{52, 1'b1, 3'd1, 1'b0}, '{53, 1'b0, 3'd1, 1'b0},
                    '{102, 1'b1, 3'd1, 1'b1}, '{103, 1'b1, 3'd0, 1'b0}, '{104, 1'b0, 3'd0, 1'b0},
                    '{153, 1'b1, 3'd0, 1'b1}, '{154, 1'b1, 3'd0, 1'b0}};
        fill_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h46};

        repeat (3) tick();
        chk("rst_serial", serial, 1);
        chk("rst_ready", ready, 1);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // single byte, exact edge timing
        base = done_cnt;
        edge_n = -1;
        write_byte(8'hA5);
        chk("one_count_e0", count, 1);
        chk("one_serial_e0", serial, 1);
        tick();
        chk("one_serial_e1", serial, 1);
        chk("one_count_e1", count, 0);
        tick();
        chk("one_start_e2", serial, 0);
        chk("one_active_e2", active, 1);
        goto_edge(50);
        chk("one_done_e50", done, 0);
        tick();
        chk("one_done_e51", done, 1);
        chk("one_active_e51", active, 1);
        chk("one_stop_e51", serial, 1);
        tick();
        chk("one_done_e52", done, 0);
        chk("one_active_e52", active, 0);
        chk("one_done_pulses", done_cnt - base, 1);
        rx_chk("one_frame", 10'b1_10100101_0);

        foreach (vecs[i]) begin
            base = done_cnt;
            write_byte(vecs[i].data);
            wait_done(base + 1);
            rx_chk($sformatf("vec%0d_frame", i), vecs[i].line);
            chk($sformatf("vec%0d_count", i), count, 0);
        end

        // back-to-back frames with one idle clock between them
        base = done_cnt;
        edge_n = -1;
        dv = 1'b1;
        tx_byte = 8'h00;
        tick();
        chk("b2b_count_e0", count, 1);
        tx_byte = 8'hFF;
        tick();
        chk("b2b_count_e1", count, 1);
        tx_byte = 8'h3C;
        tick();
        chk("b2b_count_e2", count, 2);
        dv = 1'b0;
        chk("b2b_start_e2", serial, 0);
        foreach (b2b_pts[i]) begin
            goto_edge(b2b_pts[i].e);
            chk($sformatf("b2b_serial_e%0d", b2b_pts[i].e), serial, b2b_pts[i].serial);
            chk($sformatf("b2b_count_e%0d", b2b_pts[i].e), count, b2b_pts[i].count);
            chk($sformatf("b2b_done_e%0d", b2b_pts[i].e), done, b2b_pts[i].done);
        end
        chk("b2b_active_end", active, 0);
        chk("b2b_done_pulses", done_cnt - base, 3);
        rx_chk("b2b_frame0", 10'b1_00000000_0);
        rx_chk("b2b_frame1", 10'b1_11111111_0);
        rx_chk("b2b_frame2", 10'b1_00111100_0);

        // fill with i_Tx_DV held, then one more slot opens after the first pop
        base = done_cnt;
        edge_n = -1;
        for (int e = 0; e <= 56; e++) begin
            dv = 1'b1;
            tx_byte = 8'(16 + e);
            tick();
            foreach (fill_pts[i])
                if (fill_pts[i].e == e) begin
                    chk($sformatf("fill_count_e%0d", e), count, fill_pts[i].count);
                    chk($sformatf("fill_ready_e%0d", e), ready, fill_pts[i].ready);
                end
        end
        dv = 1'b0;
        wait_done(base + 6);
        foreach (fill_bytes[i]) rx_chk($sformatf("fill_frame%0d", i), {1'b1, fill_bytes[i], 1'b0});
        chk("fill_extra_frames", rx_q.size(), 0);

        // reset during data bit 3
        base = done_cnt;
        edge_n = -1;
        dv = 1'b1;
        tx_byte = 8'hC3;
        tick();
        tx_byte = 8'h77;
        tick();
        dv = 1'b0;
        chk("mid_count_e1", count, 1);
        goto_edge(24);
        chk("mid_bit3_e24", serial, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_serial", serial, 1);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready", ready, 1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        chk("mid_no_done", done_cnt - base, 0);
        chk("mid_no_frame", rx_q.size(), 0);
        write_byte(8'h81);
        wait_done(base + 1);
        rx_chk("mid_after_frame", 10'b1_10000001_0);
        chk("mid_after_extra", rx_q.size(), 0);

        // loopback with random bytes
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            base = done_cnt;
            write_byte(b);
            wait_done(base + 1);
            rx_chk($sformatf("loop%0d", i), {1'b1, b, 1'b0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
